// File: rtl/rgb_led_top.sv
// rtl/rgb_led_top.sv - single RGB LED colour stepper driven by one push-button, PWM dimmed
//
// Purpose:
//   Each press of the push-button advances the colour in the order
//   OFF -> RED -> GREEN -> BLUE -> WHITE -> OFF.
//   A free-running counter dims the lit channels.
//   The raw button goes through a two-flop synchroniser and then a rising-edge detector.
//   All I/O is pin-level.
//
// Optional feature:
//   DEBOUNCE_EN - when defined, a stable-level filter sits between the synchroniser and the edge
//                 detector. A level change must persist for DEBOUNCE_CYCLES consecutive clocks
//                 before the detector sees it.
//
// Parameters:
//   PWM_BITS        width of the free-running PWM counter (period = 2**PWM_BITS clocks)
//   PWM_DUTY        channels lit while pwm_cnt < PWM_DUTY
//   DEBOUNCE_CYCLES stable-sample count used by the DEBOUNCE_EN filter (1..255)
//
// Ports:
//   clk     in   system clock, rising edge
//   reset   in   synchronous, active-high reset
//   button  in   raw push-button, active-high, asynchronous to clk
//   red     out  red LED channel, active-high
//   green   out  green LED channel, active-high
//   blue    out  blue LED channel, active-high

module rgb_led_top #(
    parameter int unsigned PWM_BITS        = 4,
    parameter int unsigned PWM_DUTY        = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic button,
    output logic red,
    output logic green,
    output logic blue
);

    typedef enum logic [2:0] {
        ST_OFF   = 3'd0,
        ST_RED   = 3'd1,
        ST_GREEN = 3'd2,
        ST_BLUE  = 3'd3,
        ST_WHITE = 3'd4
    } colour_t;

    // The debounce counter is 8 bits wide, so the threshold must fit in it and be non-zero.
    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_bad_debounce_cycles
        $error("rgb_led_top: DEBOUNCE_CYCLES must be in 1..255");
    end

    // ------------------------------------------------------------------
    // Button synchroniser
    // ------------------------------------------------------------------
    logic s1;
    logic s2;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= button;
            s2 <= s1;
        end
    end

    // ------------------------------------------------------------------
    // Optional stable-level filter
    // ------------------------------------------------------------------
    logic filtered;

`ifdef DEBOUNCE_EN
    logic       level;
    logic [7:0] db_cnt;

    // db_cnt counts consecutive clocks on which s2 disagrees with the accepted level.
    // Any agreeing clock clears it, so a glitch shorter than the threshold never flips the level.
    always_ff @(posedge clk) begin
        if (reset) begin
            level  <= 1'b0;
            db_cnt <= 8'd0;
        end else if (s2 != level) begin
            if (db_cnt + 8'd1 == 8'(DEBOUNCE_CYCLES)) begin
                level  <= s2;
                db_cnt <= 8'd0;
            end else begin
                db_cnt <= db_cnt + 8'd1;
            end
        end else begin
            db_cnt <= 8'd0;
        end
    end

    assign filtered = level;
`else
    assign filtered = s2;
`endif

    // ------------------------------------------------------------------
    // Rising-edge detector: one-cycle press pulse per low-to-high transition
    // ------------------------------------------------------------------
    logic filtered_q;
    logic press;

    always_ff @(posedge clk) begin
        if (reset) begin
            filtered_q <= 1'b0;
        end else begin
            filtered_q <= filtered;
        end
    end

    assign press = filtered & ~filtered_q;

    // ------------------------------------------------------------------
    // Free-running PWM counter
    // ------------------------------------------------------------------
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                pwm_on;

    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    // The compare is done at 32 bits, so PWM_DUTY >= 2**PWM_BITS yields "always lit".
    assign pwm_on = (32'(pwm_cnt) < PWM_DUTY);

    // ------------------------------------------------------------------
    // Colour state machine
    // ------------------------------------------------------------------
    colour_t state;
    colour_t state_next;
    logic    r;
    logic    g;
    logic    b;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_OFF;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        r          = 1'b0;
        g          = 1'b0;
        b          = 1'b0;
        case (state)
            ST_OFF: begin
                if (press) state_next = ST_RED;
            end
            ST_RED: begin
                r = 1'b1;
                if (press) state_next = ST_GREEN;
            end
            ST_GREEN: begin
                g = 1'b1;
                if (press) state_next = ST_BLUE;
            end
            ST_BLUE: begin
                b = 1'b1;
                if (press) state_next = ST_WHITE;
            end
            ST_WHITE: begin
                r = 1'b1;
                g = 1'b1;
                b = 1'b1;
                if (press) state_next = ST_OFF;
            end
            // Codes 5-7 cannot be reached normally.
            // If an upset lands here, recover to OFF on the next edge.
            default: begin
                state_next = ST_OFF;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Pin outputs
    // ------------------------------------------------------------------
    assign red   = r & pwm_on;
    assign green = g & pwm_on;
    assign blue  = b & pwm_on;

endmodule

// File: tb/tb_rgb_led_top.sv
// tb/tb_rgb_led_top.sv - self-checking bench for rgb_led_top against a sample-history colour model

module tb_rgb_led_top;

    logic clk    = 1'b0;
    logic reset  = 1'b1;
    logic button = 1'b0;
    logic red;
    logic green;
    logic blue;

    always #5 clk = ~clk;

    rgb_led_top dut (
        .clk   (clk),
        .reset (reset),
        .button(button),
        .red   (red),
        .green (green),
        .blue  (blue)
    );

    localparam int PERIOD = 16;
    localparam int DUTY   = 8;
    localparam int DB     = 4;
`ifdef DEBOUNCE_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    int tests = 0;
    int fails = 0;

    // cum[i] holds the number of accepted rising edges among button samples 0..i since the last reset.
    // The queue length is the count of non-reset edges, which is also the PWM phase.
    int cum[$];
    bit prev_lvl  = 1'b0;
    bit filt_lvl  = 1'b0;
    int filt_run  = 0;

    function automatic logic [2:0] colour_rgb(input int c);
        case (c)
            1:       return 3'b100;
            2:       return 3'b010;
            3:       return 3'b001;
            4:       return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    task automatic step(input bit b, input bit r, input string tag);
        bit         lvl;
        int         adv;
        int         n;
        logic [2:0] exp_rgb;
        button = b;
        reset  = r;
        @(posedge clk);
        #1;
        if (r) begin
            cum.delete();
            prev_lvl = 1'b0;
            filt_lvl = 1'b0;
            filt_run = 0;
        end else begin
`ifdef DEBOUNCE_EN
            if (b != filt_lvl) begin
                filt_run++;
                if (filt_run == DB) begin
                    filt_lvl = b;
                    filt_run = 0;
                end
            end else begin
                filt_run = 0;
            end
            lvl = filt_lvl;
`else
            lvl = b;
`endif
            n = cum.size();
            cum.push_back(((n > 0) ? cum[n-1] : 0) + ((lvl && !prev_lvl) ? 1 : 0));
            prev_lvl = lvl;
        end
        n       = cum.size();
        adv     = (n > LAT) ? cum[n-1-LAT] : 0;
        exp_rgb = colour_rgb(adv % 5);
        if ((n % PERIOD) >= DUTY) exp_rgb = 3'b000;
        tests++;
        assert ({red, green, blue} === exp_rgb)
        else begin
            fails++;
            $error("FAIL %s rgb observed=%b expected=%b", tag, {red, green, blue}, exp_rgb);
        end
    endtask

    task automatic idle(input int cycles, input string tag);
        for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, tag);
    endtask

    task automatic pulse(input int len, input string tag);
        for (int i = 0; i < len; i++) step(1'b1, 1'b0, tag);
    endtask

    initial begin
        // 1: reset held three clocks, then idle
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, "reset_hold");
        idle(100, "reset_idle");

        // 2: single one-clock press -> RED blinking 8/8
        pulse(1, "press_red");
        idle(40, "red_pwm");

        // 3: five spaced presses walk the whole colour ring
        step(1'b0, 1'b1, "reset_ring");
        for (int k = 0; k < 5; k++) begin
            pulse(1, "ring_press");
            idle(20, "ring_hold");
        end

        // 4: button held high for 40 clocks -> exactly one advance
        step(1'b0, 1'b1, "reset_held");
        pulse(40, "held_high");
        idle(20, "held_release");

        // 5: reset while BLUE
        step(1'b0, 1'b1, "reset_blue");
        for (int k = 0; k < 3; k++) begin
            pulse(1, "to_blue");
            idle(6, "to_blue_gap");
        end
        idle(5, "in_blue");
        step(1'b1, 1'b1, "reset_in_blue");
        idle(20, "after_blue_reset");

        // 5b: reset coinciding with the press pulse loses the press
        pulse(1, "late_press");
        step(1'b0, 1'b0, "late_press_e1");
        step(1'b0, 1'b1, "reset_on_press");
        idle(10, "press_lost");

`ifdef DEBOUNCE_EN
        // 6: short glitch is rejected, long press advances
        step(1'b0, 1'b1, "reset_db");
        pulse(2, "db_short");
        idle(20, "db_short_idle");
        pulse(6, "db_long");
        idle(20, "db_long_idle");
`endif

        // randomized runs of button levels with occasional resets
        for (int k = 0; k < 400; k++) begin
            bit lv;
            int len;
            lv  = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 8);
            if ($urandom_range(0, 39) == 0) begin
                step(lv, 1'b1, "rand_reset");
            end
            for (int i = 0; i < len; i++) step(lv, 1'b0, "rand_run");
        end
        idle(20, "final_idle");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
